sync_fifo_prog: RTL and testbench
=================================

// Module: sync_fifo_prog
// PURPOSE
//  Single-clock FIFO for the same domain as the existing async FIFO; it is the parametrised next generation of that buffer.
//  Adds programmable almost-full/almost-empty thresholds, a fill count, a synchronous flush and a selectable
//  standard or first-word-fall-through (FWFT) read mode. Sits between a producer and a consumer in one clock domain.
// PARAMETERS
//  DEPTH       16  entries; power of 2, >= 2
//  DATA_WIDTH  8   word width in bits
//  ADDR_WIDTH  $clog2(DEPTH)  memory address width; derived, do not override
//  AF_LEVEL    12  almost_full_o asserts when count >= AF_LEVEL; legal range 1..DEPTH
//  AE_LEVEL    2   almost_empty_o asserts when count <= AE_LEVEL; legal range 0..DEPTH-1
//  FWFT        0   0 = standard registered read, 1 = first-word-fall-through
// PORTS
//  clk_i           in   1             single clock, rising edge
//  rst_ni          in   1             asynchronous reset, active low
//  clr_i           in   1             synchronous flush
//  wr_en_i         in   1             write request
//  wr_data_i       in   DATA_WIDTH    write data
//  full_o          out  1             count == DEPTH
//  almost_full_o   out  1             count >= AF_LEVEL
//  overflow_o      out  1             1-cycle pulse: a write was rejected
//  rd_en_i         in   1             read request (pop)
//  rd_data_o       out  DATA_WIDTH    read data
//  rd_valid_o      out  1             rd_data_o holds popped (STD) or head (FWFT) data
//  empty_o         out  1             count == 0
//  almost_empty_o  out  1             count <= AE_LEVEL
//  underflow_o     out  1             1-cycle pulse: a read was rejected
//  count_o         out  ADDR_WIDTH+1  occupancy, 0..DEPTH
// BEHAVIOUR
//  - Reset (rst_ni=0, takes effect immediately, no clock needed): the pointers, count_o, overflow_o, underflow_o,
//    rd_valid_o, rd_data_o, full_o and almost_full_o all go to 0. empty_o and almost_empty_o go to 1.
//    Memory contents are not reset.
//  - Pointers are ADDR_WIDTH+1 bits wide. The MSB is a wrap bit; addresses wrap naturally from DEPTH-1 to 0.
//  - A write is accepted when wr_en_i && !full_o. A read is accepted when rd_en_i && !empty_o. Both decisions use
//    the registered flags.
//  - Write + read in the same cycle: each is judged independently.
//      At full: the read is accepted; the write is rejected and overflow_o pulses; count becomes DEPTH-1.
//      At empty: the write is accepted; the read is rejected and underflow_o pulses; count becomes 1.
//      Otherwise: both are accepted and count is unchanged.
//  - A rejected op changes no state. overflow_o/underflow_o are registered and high for exactly the cycle after the
//    rejected request.
//  - count_o updates at the edge of an accepted op. All four flags decode from the count register, so they change
//    in the cycle after the op.
//  - Standard mode (FWFT=0):
//      an accepted read registers mem[rd_ptr] into rd_data_o and pulses rd_valid_o for 1 cycle (read latency 1);
//      rd_data_o holds its last value otherwise.
//  - FWFT mode (FWFT=1):
//      rd_data_o = mem[rd_ptr] combinationally; rd_valid_o = !empty_o;
//      a write to an empty FIFO is visible on rd_data_o 1 cycle later; rd_en_i pops the head.
//  - clr_i=1 at an edge:
//      pointers and count go to 0 and rd_valid_o goes to 0;
//      clr_i overrides any wr_en_i/rd_en_i in the same cycle; those requests are dropped with no overflow/underflow;
//      memory is untouched.
//  - Illegal parameter values (DEPTH not a power of 2, AF_LEVEL or AE_LEVEL out of range) stop elaboration
//    through a generate-time error.
// STRUCTURE
//  - Shared package fifo_pkg holds: mode constants FIFO_MODE_STD=0 and FIFO_MODE_FWFT=1, and the clog2 helper.
//    The async and sync FIFOs share it.
//  - Sub-module fifo_mem_1r1w (DEPTH x DATA_WIDTH register array; synchronous write, asynchronous read) is
//    reusable by the async FIFO.
//  - The top level holds the pointers, the count, flag decode, pulse registers and the read-mode generate branch.
// TESTING (DEPTH=16, DATA_WIDTH=8, AF_LEVEL=12, AE_LEVEL=2)
//  1. Reset, then idle -> empty_o=1, almost_empty_o=1, full_o=0, count_o=0, rd_valid_o=0.
//     Assert rst_ni low at count=9 with no clock edge -> same values immediately.
//  2. Write 0x00..0x0F:
//       almost_empty_o drops after the 3rd write; almost_full_o rises after the 12th; full_o rises after the 16th;
//       count_o=16.
//     17th write of 0xAA -> overflow_o high for 1 cycle, count_o stays 16.
//     16 reads (STD) -> 0x00..0x0F in order, rd_valid_o 1 cycle after each rd_en_i, 0xAA never seen.
//  3. Write 2, then read 3 -> the 3rd read gives underflow_o for 1 cycle, no rd_valid_o, count_o=0.
//  4. Simultaneous write + read:
//       at count=5 for 10 cycles -> count_o stays 5, data order preserved;
//       at full -> count_o=15, overflow_o=1;
//       at empty -> count_o=1, underflow_o=1.
//  5. Wrap: write 10, read 10, write 10, read 10 -> pointers cross DEPTH, data in order, empty_o=1 at the end.
//     clr_i at count=7 together with wr_en_i -> count_o=0, empty_o=1, overflow_o=0.
//  6. FWFT=1 instance: write 0x5A into an empty FIFO -> the next cycle shows empty_o=0, rd_valid_o=1,
//     rd_data_o=0x5A with no rd_en_i; one rd_en_i -> empty_o=1 the following cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// Definitions shared by the single-clock and dual-clock FIFO families:
// read-mode selectors and a constant-foldable ceil(log2) helper.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Smallest n with 2**n >= value; usable in parameter defaults.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_mem_1r1w.sv
// DEPTH x DATA_WIDTH register array with one synchronous write port and one
// asynchronous read port; contents are deliberately left unreset.
module fifo_mem_1r1w #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with fill count, programmable almost-full/almost-empty
// levels, synchronous flush and a standard or first-word-fall-through read port.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = clog2(DEPTH),
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = FIFO_MODE_STD
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  full_o,
  output logic                  almost_full_o,
  output logic                  overflow_o,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  empty_o,
  output logic                  almost_empty_o,
  output logic                  underflow_o,
  output logic [ADDR_WIDTH:0]   count_o
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_AF   = CNT_W'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] CNT_AE   = CNT_W'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0] ONE      = CNT_W'(1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ADDR_WIDTH != clog2(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_prog: DEPTH must be a power of 2 >= 2 and ADDR_WIDTH left at its default");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo_prog: AF_LEVEL must lie in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_prog: AE_LEVEL must lie in 0..DEPTH-1");
  end

  // Handshake: a write is taken on a rising edge when wr_en_i && !full_o, a
  // read when rd_en_i && !empty_o; both flags are decoded from the count
  // register, so a request is judged against the state before that edge.
  // clr_i wins over both requests and raises no overflow/underflow.
  logic [ADDR_WIDTH:0]   wr_ptr_q;
  logic [ADDR_WIDTH:0]   rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  wr_accept;
  logic                  rd_accept;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign full_o         = (count_q == CNT_FULL);
  assign empty_o        = (count_q == '0);
  assign almost_full_o  = (count_q >= CNT_AF);
  assign almost_empty_o = (count_q <= CNT_AE);
  assign count_o        = count_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

  assign wr_accept = wr_en_i & ~full_o & ~clr_i;
  assign rd_accept = rd_en_i & ~empty_o & ~clr_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= wr_en_i & full_o & ~clr_i;
      underflow_q <= rd_en_i & empty_o & ~clr_i;
      if (clr_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (wr_accept) begin
          wr_ptr_q <= wr_ptr_q + ONE;
        end
        if (rd_accept) begin
          rd_ptr_q <= rd_ptr_q + ONE;
        end
        if (wr_accept && !rd_accept) begin
          count_q <= count_q + ONE;
        end else if (rd_accept && !wr_accept) begin
          count_q <= count_q - ONE;
        end
      end
    end
  end

  fifo_mem_1r1w #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk_i     (clk_i),
    .wr_en_i   (wr_accept),
    .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wr_data_i (wr_data_i),
    .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_data_o (mem_rdata)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    // Head word is shown directly; masked to zero while empty so reset and
    // flush present a defined value instead of stale memory.
    assign rd_data_o  = empty_o ? '0 : mem_rdata;
    assign rd_valid_o = ~empty_o;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_accept;
        if (rd_accept) begin
          rd_data_q <= mem_rdata;
        end
      end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Self-checking bench for sync_fifo_prog: a standard-mode instance checked
// against a count/flag model plus a data scoreboard, and an FWFT instance.
module tb_sync_fifo_prog;

  localparam int DEPTH = 16;
  localparam int DW    = 8;
  localparam int AF    = 12;
  localparam int AE    = 2;

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic          full, afull, ovf, rd_valid, empty, aempty, unf;
  logic [DW-1:0] rd_data;
  logic [4:0]    count;

  logic          f_clr;
  logic          f_wr_en;
  logic [DW-1:0] f_wr_data;
  logic          f_rd_en;
  logic          f_full, f_afull, f_ovf, f_rd_valid, f_empty, f_aempty, f_unf;
  logic [DW-1:0] f_rd_data;
  logic [4:0]    f_count;

  int n_cmp = 0;
  int n_err = 0;
  int m_cnt = 0;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic          w;
    logic [DW-1:0] d;
    logic          r;
    logic          c;
    int            exp_cnt;
    logic          exp_ovf;
    logic          exp_unf;
  } vec_t;

  vec_t vecs[8];

  // ---------------- clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_prog #(
    .DEPTH (DEPTH), .DATA_WIDTH (DW), .AF_LEVEL (AF), .AE_LEVEL (AE), .FWFT (0)
  ) dut (
    .clk_i (clk), .rst_ni (rst_n), .clr_i (clr),
    .wr_en_i (wr_en), .wr_data_i (wr_data),
    .full_o (full), .almost_full_o (afull), .overflow_o (ovf),
    .rd_en_i (rd_en), .rd_data_o (rd_data), .rd_valid_o (rd_valid),
    .empty_o (empty), .almost_empty_o (aempty), .underflow_o (unf),
    .count_o (count)
  );

  sync_fifo_prog #(
    .DEPTH (DEPTH), .DATA_WIDTH (DW), .AF_LEVEL (AF), .AE_LEVEL (AE), .FWFT (1)
  ) dut_fwft (
    .clk_i (clk), .rst_ni (rst_n), .clr_i (f_clr),
    .wr_en_i (f_wr_en), .wr_data_i (f_wr_data),
    .full_o (f_full), .almost_full_o (f_afull), .overflow_o (f_ovf),
    .rd_en_i (f_rd_en), .rd_data_o (f_rd_data), .rd_valid_o (f_rd_valid),
    .empty_o (f_empty), .almost_empty_o (f_aempty), .underflow_o (f_unf),
    .count_o (f_count)
  );

  // ---------------- checker
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver: one clock with model prediction and scoreboard
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
    logic full_m, empty_m, wacc, racc, ovf_e, unf_e;
    logic [DW-1:0] exp_d;
    full_m  = (m_cnt == DEPTH);
    empty_m = (m_cnt == 0);
    wacc    = w && !full_m && !c;
    racc    = r && !empty_m && !c;
    ovf_e   = w && full_m && !c;
    unf_e   = r && empty_m && !c;
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    clr     = c;
    if (c) exp_q.delete();
    else if (wacc) exp_q.push_back(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    clr   = 1'b0;
    m_cnt = c ? 0 : m_cnt + int'(wacc) - int'(racc);
    check("count", 32'(count), 32'(m_cnt));
    check("empty", 32'(empty), 32'(m_cnt == 0));
    check("full", 32'(full), 32'(m_cnt == DEPTH));
    check("almost_full", 32'(afull), 32'(m_cnt >= AF));
    check("almost_empty", 32'(aempty), 32'(m_cnt <= AE));
    check("overflow", 32'(ovf), 32'(ovf_e));
    check("underflow", 32'(unf), 32'(unf_e));
    check("rd_valid", 32'(rd_valid), 32'(racc));
    if (racc || rd_valid) begin
      if (exp_q.size() == 0) begin
        check("sb_nonempty", 32'(rd_valid), 32'(0));
      end else begin
        exp_d = exp_q.pop_front();
        check("rd_data", 32'(rd_data), 32'(exp_d));
      end
    end
  endtask

  task automatic fill(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) cycle(1'b1, base + DW'(i), 1'b0, 1'b0);
  endtask

  task automatic drain();
    while (m_cnt > 0) cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  // ---------------- stimulus
  initial begin
    vecs[0] = '{w: 1'b1, d: 8'h11, r: 1'b0, c: 1'b0, exp_cnt: 1, exp_ovf: 1'b0, exp_unf: 1'b0};
    vecs[1] = '{w: 1'b1, d: 8'h22, r: 1'b0, c: 1'b0, exp_cnt: 2, exp_ovf: 1'b0, exp_unf: 1'b0};
    vecs[2] = '{w: 1'b0, d: 8'h00, r: 1'b1, c: 1'b0, exp_cnt: 1, exp_ovf: 1'b0, exp_unf: 1'b0};
    vecs[3] = '{w: 1'b0, d: 8'h00, r: 1'b1, c: 1'b0, exp_cnt: 0, exp_ovf: 1'b0, exp_unf: 1'b0};
    vecs[4] = '{w: 1'b0, d: 8'h00, r: 1'b1, c: 1'b0, exp_cnt: 0, exp_ovf: 1'b0, exp_unf: 1'b1};
    vecs[5] = '{w: 1'b0, d: 8'h00, r: 1'b0, c: 1'b0, exp_cnt: 0, exp_ovf: 1'b0, exp_unf: 1'b0};
    vecs[6] = '{w: 1'b1, d: 8'h33, r: 1'b1, c: 1'b0, exp_cnt: 1, exp_ovf: 1'b0, exp_unf: 1'b1};
    vecs[7] = '{w: 1'b0, d: 8'h00, r: 1'b1, c: 1'b0, exp_cnt: 0, exp_ovf: 1'b0, exp_unf: 1'b0};

    rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
    f_clr = 1'b0; f_wr_en = 1'b0; f_wr_data = '0; f_rd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1. reset state, idle
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("rst_empty", 32'(empty), 32'(1));
    check("rst_almost_empty", 32'(aempty), 32'(1));
    check("rst_full", 32'(full), 32'(0));
    check("rst_count", 32'(count), 32'(0));
    check("rst_rd_valid", 32'(rd_valid), 32'(0));

    // asynchronous reset at count=9 with no clock edge
    fill(10, 8'hC0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", 32'(count), 32'(0));
    check("arst_empty", 32'(empty), 32'(1));
    check("arst_almost_empty", 32'(aempty), 32'(1));
    check("arst_full", 32'(full), 32'(0));
    check("arst_almost_full", 32'(afull), 32'(0));
    check("arst_rd_valid", 32'(rd_valid), 32'(0));
    check("arst_rd_data", 32'(rd_data), 32'(0));
    #1 rst_n = 1'b1;
    m_cnt = 0;
    exp_q.delete();
    @(posedge clk);
    #1;

    // 2. fill 0x00..0x0F, overflow, drain in order
    fill(2, 8'h00);
    check("ae_after_2", 32'(aempty), 32'(1));
    fill(1, 8'h02);
    check("ae_after_3", 32'(aempty), 32'(0));
    fill(8, 8'h03);
    check("af_after_11", 32'(afull), 32'(0));
    fill(1, 8'h0B);
    check("af_after_12", 32'(afull), 32'(1));
    fill(3, 8'h0C);
    check("full_after_15", 32'(full), 32'(0));
    fill(1, 8'h0F);
    check("full_after_16", 32'(full), 32'(1));
    check("count_16", 32'(count), 32'(16));
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    check("ovf_pulse", 32'(ovf), 32'(1));
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("ovf_one_cycle", 32'(ovf), 32'(0));
    check("count_still_16", 32'(count), 32'(16));
    drain();

    // 3. table-driven: write 2, read 3, simultaneous at empty
    for (int i = 0; i < 8; i++) begin
      cycle(vecs[i].w, vecs[i].d, vecs[i].r, vecs[i].c);
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_cnt));
      check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
      check($sformatf("vec%0d_unf", i), 32'(unf), 32'(vecs[i].exp_unf));
    end

    // 4. simultaneous write+read at count=5 and at full
    fill(5, 8'h50);
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'h60 + DW'(i), 1'b1, 1'b0);
    check("wr_rd_count5", 32'(count), 32'(5));
    fill(11, 8'h80);
    cycle(1'b1, 8'hEE, 1'b1, 1'b0);
    check("full_wr_rd_count", 32'(count), 32'(15));
    check("full_wr_rd_ovf", 32'(ovf), 32'(1));
    drain();
    cycle(1'b1, 8'h3C, 1'b1, 1'b0);
    check("empty_wr_rd_count", 32'(count), 32'(1));
    check("empty_wr_rd_unf", 32'(unf), 32'(1));
    drain();

    // 5. pointer wrap, then flush with a concurrent write
    for (int k = 0; k < 2; k++) begin
      fill(10, 8'hA0 + DW'(16 * k));
      for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    end
    check("wrap_empty", 32'(empty), 32'(1));
    for (int i = 0; i < 20; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
    end
    drain();
    fill(7, 8'h70);
    cycle(1'b1, 8'h77, 1'b0, 1'b1);
    check("clr_count", 32'(count), 32'(0));
    check("clr_empty", 32'(empty), 32'(1));
    check("clr_ovf", 32'(ovf), 32'(0));
    fill(2, 8'h90);
    drain();

    // 6. FWFT instance
    check("fwft_idle_valid", 32'(f_rd_valid), 32'(0));
    check("fwft_idle_empty", 32'(f_empty), 32'(1));
    f_wr_en = 1'b1; f_wr_data = 8'h5A;
    @(posedge clk); #1;
    f_wr_en = 1'b0;
    check("fwft_empty", 32'(f_empty), 32'(0));
    check("fwft_valid", 32'(f_rd_valid), 32'(1));
    check("fwft_data", 32'(f_rd_data), 32'(8'h5A));
    f_wr_en = 1'b1; f_wr_data = 8'hC3;
    @(posedge clk); #1;
    f_wr_en = 1'b0;
    check("fwft_head_held", 32'(f_rd_data), 32'(8'h5A));
    f_rd_en = 1'b1;
    @(posedge clk); #1;
    f_rd_en = 1'b0;
    check("fwft_next_head", 32'(f_rd_data), 32'(8'hC3));
    check("fwft_count1", 32'(f_count), 32'(1));
    f_rd_en = 1'b1;
    @(posedge clk); #1;
    f_rd_en = 1'b0;
    check("fwft_empty_after_pop", 32'(f_empty), 32'(1));
    check("fwft_valid_after_pop", 32'(f_rd_valid), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
